// File: rtl/defect_overlay_if.sv
// Pixel stream and defect-coordinate bundle for defect_overlay.
// slave is the overlay side; master is the video source / sink.
interface defect_overlay_if #(
   parameter int unsigned COORD_WID = 11
);
   logic [COORD_WID-1:0] defect_p1_x;
   logic [COORD_WID-1:0] defect_p1_y;
   logic [COORD_WID-1:0] defect_p2_x;
   logic [COORD_WID-1:0] defect_p2_y;
   logic [COORD_WID-1:0] defect_p3_x;
   logic [COORD_WID-1:0] defect_p3_y;
   logic [COORD_WID-1:0] defect_p4_x;
   logic [COORD_WID-1:0] defect_p4_y;
   logic                 defect_valid;
   logic                 in_vs;
   logic                 in_de;
   logic [23:0]          in_data;
   logic                 out_vs;
   logic                 out_de;
   logic [23:0]          out_data;

   modport master (
      output defect_p1_x, defect_p1_y,
      output defect_p2_x, defect_p2_y,
      output defect_p3_x, defect_p3_y,
      output defect_p4_x, defect_p4_y,
      output defect_valid,
      output in_vs, in_de, in_data,
      input  out_vs, out_de, out_data
   );

   modport slave (
      input  defect_p1_x, defect_p1_y,
      input  defect_p2_x, defect_p2_y,
      input  defect_p3_x, defect_p3_y,
      input  defect_p4_x, defect_p4_y,
      input  defect_valid,
      input  in_vs, in_de, in_data,
      output out_vs, out_de, out_data
   );
endinterface

// File: rtl/defect_overlay.sv
// Draws a defect bounding box (and optional point markers) over RGB888 video.
// Define DEFECT_OVERLAY_MARK_EN to add the cross markers on the four points.
module defect_overlay #(
   parameter int unsigned          COORD_WID  = 11,
   parameter logic [COORD_WID-1:0] IMG_WIDTH  = 11'd640,
   parameter logic [COORD_WID-1:0] IMG_HEIGHT = 11'd480,
   parameter int unsigned          MARK_HALF  = 4,
   parameter logic [23:0]          BOX_COLOR  = 24'hFF0000,
   parameter logic [23:0]          MARK_COLOR = 24'h00FF00
) (
   input logic             pixclk_in,
   input logic             rst_out,
   defect_overlay_if.slave bus
);

   localparam int unsigned EW = COORD_WID + 1;

   typedef logic [COORD_WID-1:0] crd_t;
   typedef logic [EW-1:0]        ext_t;

   localparam crd_t X_MAX = IMG_WIDTH - 1'b1;
   localparam crd_t Y_MAX = IMG_HEIGHT - 1'b1;

   typedef struct packed {
      crd_t [3:0] px;
      crd_t [3:0] py;
      logic       valid;
   } shadow_t;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      BLANK   = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   state_t      state_q;
   logic        vs_prev_q;
   logic        de_prev_q;
   crd_t        x_q;
   crd_t        x_d;
   crd_t        y_q;
   crd_t        y_d;
   shadow_t     sh_q;
   shadow_t     sh_d;
   shadow_t     sh_in;

   logic        vs_rise;
   logic        de_fall;
   logic        draw;
   crd_t        pix_x;
   crd_t        pix_y;
   logic        x_in;
   logic        y_in;
   logic        on_edge;
   logic        box_ok;
   logic        box_hit;

   logic        s1_vs_q;
   logic        s1_de_q;
   logic [23:0] s1_data_q;
   logic        s1_box_q;

   logic        out_vs_q;
   logic        out_de_q;
   logic [23:0] out_data_q;
   logic [23:0] data_d;
   logic        mark_sel;
   logic        box_sel;

   assign sh_in = {
      bus.defect_p4_x, bus.defect_p3_x,
      bus.defect_p2_x, bus.defect_p1_x,
      bus.defect_p4_y, bus.defect_p3_y,
      bus.defect_p2_y, bus.defect_p1_y,
      bus.defect_valid
   };

   assign vs_rise = bus.in_vs & ~vs_prev_q;
   assign de_fall = ~bus.in_de & de_prev_q;

   // A pixel arriving on the vs edge already belongs to the new frame.
   assign sh_d  = vs_rise ? sh_in : sh_q;
   assign pix_x = x_q;
   assign pix_y = vs_rise ? '0 : y_q;

   assign draw = bus.in_de & sh_d.valid
               & (vs_rise | (state_q != WAIT_VS));

   always_comb begin
      x_d = x_q;
      unique case (1'b1)
         bus.in_de: x_d = (x_q == X_MAX) ? x_q : x_q + 1'b1;
         de_fall:   x_d = '0;
         default:   x_d = x_q;
      endcase
   end

   always_comb begin
      y_d = y_q;
      if (vs_rise)
         y_d = '0;
      else if (de_fall && (y_q != Y_MAX))
         y_d = y_q + 1'b1;
   end

   assign box_ok  = (sh_d.px[0] <= sh_d.px[1])
                  & (sh_d.py[2] <= sh_d.py[3]);
   assign x_in    = (pix_x >= sh_d.px[0])
                  & (pix_x <= sh_d.px[1]);
   assign y_in    = (pix_y >= sh_d.py[2])
                  & (pix_y <= sh_d.py[3]);
   assign on_edge = (pix_x == sh_d.px[0])
                  | (pix_x == sh_d.px[1])
                  | (pix_y == sh_d.py[2])
                  | (pix_y == sh_d.py[3]);
   assign box_hit = box_ok & x_in & y_in & on_edge;

`ifdef DEFECT_OVERLAY_MARK_EN
   localparam ext_t MH = ext_t'(MARK_HALF);

   logic mark_hit;
   logic s1_mark_q;

   // Widened compare so arms near 0 cannot wrap to the far edge.
   function automatic logic near(crd_t a, crd_t p);
      ext_t ea;
      ext_t ep;
      ea = {1'b0, a};
      ep = {1'b0, p};
      return ((ea + MH) >= ep) && (ea <= (ep + MH));
   endfunction

   always_comb begin
      mark_hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if ((pix_y == sh_d.py[k]) && near(pix_x, sh_d.px[k]))
            mark_hit = 1'b1;
         if ((pix_x == sh_d.px[k]) && near(pix_y, sh_d.py[k]))
            mark_hit = 1'b1;
      end
   end

   always_ff @(posedge pixclk_in) begin
      if (rst_out)
         s1_mark_q <= 1'b0;
      else
         s1_mark_q <= draw & mark_hit;
   end

   assign mark_sel = s1_de_q & s1_mark_q;
`else
   logic unused_pts;
   assign unused_pts = ^{sh_d.px[3:2], sh_d.py[1:0],
                         MARK_COLOR, 32'(MARK_HALF)};
   assign mark_sel = 1'b0;
`endif

   assign box_sel = s1_de_q & s1_box_q & ~mark_sel;

   always_comb begin
      data_d = '0;
      unique case (1'b1)
         !s1_de_q: data_d = '0;
         mark_sel: data_d = MARK_COLOR;
         box_sel:  data_d = BOX_COLOR;
         default:  data_d = s1_data_q;
      endcase
   end

   always_ff @(posedge pixclk_in) begin
      if (rst_out) begin
         state_q <= WAIT_VS;
      end else begin
         case (state_q)
            WAIT_VS: if (vs_rise)    state_q <= BLANK;
            BLANK:   if (bus.in_de)  state_q <= ACTIVE;
            ACTIVE:  if (vs_rise)    state_q <= BLANK;
            default:                 state_q <= WAIT_VS;
         endcase
      end
   end

   always_ff @(posedge pixclk_in) begin
      if (rst_out) begin
         vs_prev_q  <= 1'b0;
         de_prev_q  <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         sh_q       <= '0;
         s1_vs_q    <= 1'b0;
         s1_de_q    <= 1'b0;
         s1_data_q  <= '0;
         s1_box_q   <= 1'b0;
         out_vs_q   <= 1'b0;
         out_de_q   <= 1'b0;
         out_data_q <= '0;
      end else begin
         vs_prev_q  <= bus.in_vs;
         de_prev_q  <= bus.in_de;
         x_q        <= x_d;
         y_q        <= y_d;
         sh_q       <= sh_d;
         s1_vs_q    <= bus.in_vs;
         s1_de_q    <= bus.in_de;
         s1_data_q  <= bus.in_data;
         s1_box_q   <= draw & box_hit;
         out_vs_q   <= s1_vs_q;
         out_de_q   <= s1_de_q;
         out_data_q <= data_d;
      end
   end

   assign bus.out_vs   = out_vs_q;
   assign bus.out_de   = out_de_q;
   assign bus.out_data = out_data_q;

endmodule
